l2_mem_fill_ctrl: RTL

- Memory-side controller of the L2 cache, sitting between the L2 miss/evict logic and the DRAM.
- Accepts one line request at a time: either a read fill or a write-back.
- Drives the DRAM command and address. Collects read bursts beat-by-beat on DRAM strobe toggles into a line buffer. Returns the assembled line, or a write acknowledge, to L2 over a valid/ready handshake.

---
 rtl/l2_mem_fill_ctrl_if.sv | 36 +++
 rtl/l2_mem_fill_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/l2_mem_fill_ctrl_if.sv
// L2 <-> fill controller <-> DRAM signal bundle; slave is the controller, master is the L2/DRAM side.
interface l2_mem_fill_ctrl_if #(
    parameter int BEATS = 8
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [31:0]           req_addr;
    logic [BEATS*64-1:0]   req_wline;

    logic                  resp_valid;
    logic                  resp_ready;
    logic                  resp_write;
    logic [31:0]           resp_addr;
    logic [BEATS*64-1:0]   resp_line;
    logic                  resp_err;

    logic                  mem_req;
    logic                  mem_cmd;
    logic [31:0]           mem_addr;
    logic [BEATS*64-1:0]   mem_wline;
    logic [63:0]           mem_data;
    logic                  mem_strobe;

    modport slave (
        input  req_valid, req_write, req_addr, req_wline, resp_ready, mem_data, mem_strobe,
        output req_ready, resp_valid, resp_write, resp_addr, resp_line, resp_err,
               mem_req, mem_cmd, mem_addr, mem_wline
    );

    modport master (
        output req_valid, req_write, req_addr, req_wline, resp_ready, mem_data, mem_strobe,
        input  req_ready, resp_valid, resp_write, resp_addr, resp_line, resp_err,
               mem_req, mem_cmd, mem_addr, mem_wline
    );
endinterface

// File: rtl/l2_mem_fill_ctrl.sv
// L2 memory fill controller: one read fill / write-back at a time; resp_valid 1 clk after the last beat or ack toggle,
// held until resp_ready; req_ready only in IDLE. Optional DRAM watchdog under MEM_TIMEOUT_EN.
module l2_mem_fill_ctrl #(
    parameter int BEATS          = 8,
    parameter int OFFSET_BITS    = 6,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    l2_mem_fill_ctrl_if.slave bus
);
    localparam int                LINE_W     = BEATS * 64;
    localparam int                CNT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0]  LAST_BEAT  = CNT_W'(BEATS - 1);
    localparam logic [31:0]       ALIGN_MASK = ~((32'h1 << OFFSET_BITS) - 32'h1);

    typedef enum logic [2:0] {
        IDLE, ISSUE, RD_BURST, WR_ACK, RESP
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                req_ready_q, req_ready_d;
    logic                resp_valid_q, resp_valid_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_cmd_q, mem_cmd_d;
    logic [31:0]         mem_addr_q, mem_addr_d;
    logic [LINE_W-1:0]   mem_wline_q, mem_wline_d;
    logic [LINE_W-1:0]   resp_line_q, resp_line_d;
    logic [31:0]         resp_addr_q, resp_addr_d;
    logic                resp_write_q, resp_write_d;
    logic                resp_err_q, resp_err_d;

    logic                strb_q, strb_qq;
    logic [63:0]         data_q;
    logic                tog;
    logic                timeout_hit;

    assign tog = strb_q ^ strb_qq;

`ifdef MEM_TIMEOUT_EN
    localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [WD_W-1:0] wd_q, wd_d;
    logic            wd_active;

    assign wd_active = (state_q == RD_BURST) || (state_q == WR_ACK);

    always_comb begin
        wd_d = '0;
        if (wd_active && !tog) begin
            wd_d = wd_q + 1'b1;
        end
    end

    // A toggle in the same cycle wins over the watchdog.
    assign timeout_hit = wd_active && !tog && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign timeout_hit    = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        mem_cmd_d    = mem_cmd_q;
        mem_addr_d   = mem_addr_q;
        mem_wline_d  = mem_wline_q;
        resp_line_d  = resp_line_q;
        resp_addr_d  = resp_addr_q;
        resp_write_d = resp_write_q;
        resp_err_d   = resp_err_q;

        case (state_q)
            IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    mem_cmd_d   = bus.req_write;
                    mem_addr_d  = bus.req_addr & ALIGN_MASK;
                    mem_wline_d = bus.req_wline;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d        = '0;
                resp_addr_d  = mem_addr_q;
                resp_write_d = mem_cmd_q;
                resp_err_d   = 1'b0;
                state_d      = mem_cmd_q ? WR_ACK : RD_BURST;
            end
            RD_BURST: begin
                if (tog) begin
                    resp_line_d[cnt_q*64 +: 64] = data_q;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_BEAT) begin
                        state_d = RESP;
                    end
                end else if (timeout_hit) begin
                    resp_err_d = 1'b1;
                    state_d    = RESP;
                end
            end
            WR_ACK: begin
                if (tog) begin
                    state_d = RESP;
                end else if (timeout_hit) begin
                    resp_err_d = 1'b1;
                    state_d    = RESP;
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    resp_err_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Handshake outputs are registered from the next state, so resp_ready never reaches req_ready combinationally.
        req_ready_d  = (state_d == IDLE);
        resp_valid_d = (state_d == RESP);
        mem_req_d    = (state_d == ISSUE) || (state_d == RD_BURST) || (state_d == WR_ACK);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_cmd_q    <= 1'b0;
            mem_addr_q   <= '0;
            mem_wline_q  <= '0;
            resp_line_q  <= '0;
            resp_addr_q  <= '0;
            resp_write_q <= 1'b0;
            resp_err_q   <= 1'b0;
            strb_q       <= 1'b0;
            strb_qq      <= 1'b0;
            data_q       <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            mem_req_q    <= mem_req_d;
            mem_cmd_q    <= mem_cmd_d;
            mem_addr_q   <= mem_addr_d;
            mem_wline_q  <= mem_wline_d;
            resp_line_q  <= resp_line_d;
            resp_addr_q  <= resp_addr_d;
            resp_write_q <= resp_write_d;
            resp_err_q   <= resp_err_d;
            strb_q       <= bus.mem_strobe;
            strb_qq      <= strb_q;
            data_q       <= bus.mem_data;
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_write = resp_write_q;
    assign bus.resp_addr  = resp_addr_q;
    assign bus.resp_line  = resp_line_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.mem_req    = mem_req_q;
    assign bus.mem_cmd    = mem_cmd_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wline  = mem_wline_q;
endmodule
